camera_reg_write_arbiter: RTL and testbench
===========================================

// Module: camera_reg_write_arbiter
// PURPOSE
//  Run-time register-write scheduler for the camera sensor I2C port. It arbitrates
//  round-robin between NUM_REQ requesters (e.g. auto-exposure, host CSR bridge),
//  serialises each 8-bit-address/16-bit-data write into one I2C transaction, and
//  retries on NACK. It sits between the requesters and the I2C transaction engine.
//  The engine is shared with the boot-time config sequencer, so writes are held off until enable=1.
// PARAMETERS
//  NUM_REQ        2         number of requesters (1..4)
//  SLAVE_ADDR     8'hBA     sensor I2C write address, placed in i2c_data[31:24]
//  MAX_RETRY      3         extra attempts after a NACK before reporting error
//  TIMEOUT_CYCLES 1000000   clock cycles allowed per wait state before abort
//  GAP_CYCLES     64        idle clock cycles between successive transactions
// PORTS
//  clock       in   1            system clock (50 MHz)
//  reset_n     in   1            asynchronous, active-low reset
//  enable      in   1            1 = arbitration allowed (driven by config-done ready)
//  req_valid   in   NUM_REQ      per-requester write request, held until accepted
//  req_addr    in   8*NUM_REQ    register address; slice i = requester i
//  req_data    in   16*NUM_REQ   register data; slice i = requester i
//  req_accept  out  NUM_REQ      1-cycle pulse: request captured, requester may drop valid
//  wr_done     out  1            1-cycle pulse: current write finished (success or error)
//  wr_error    out  1            valid with wr_done: 1 = retries exhausted or timeout
//  wr_owner    out  2            index of the requester owning the current or last write
//  busy        out  1            1 while not in IDLE
//  i2c_go      out  1            start request to the I2C engine, level
//  i2c_data    out  32           {SLAVE_ADDR, addr, data}
//  i2c_end     in   1            engine idle/end flag: 1 idle, 0 transfer in progress
//  i2c_ack     in   1            sampled on end rise: 0 = all bytes ACKed, 1 = NACK
// BEHAVIOUR
//  Reset: all outputs 0, round-robin pointer = 0, FSM = IDLE, retry/timeout/gap counters = 0.
//  i2c_end/i2c_ack pass through a 2-flop synchroniser before any use, adding 2 cycles of latency.
//  FSM:
//   IDLE      : if enable and |req_valid -> pick the first valid index at or after pointer, wrapping.
//               Capture addr/data, pulse req_accept[i], set wr_owner, and go to START.
//   START     : drive i2c_go=1 and i2c_data; go to WAIT_LOW.
//   WAIT_LOW  : wait for sync end=0, then WAIT_HIGH. On TIMEOUT, abort.
//   WAIT_HIGH : wait for sync end=1, then drop i2c_go and sample ack; go to CHECK. On TIMEOUT, abort.
//   CHECK     : if ack=0 -> DONE(ok). If ack=1 and retry<MAX_RETRY -> retry++ and GAP(then START).
//               Otherwise -> DONE(error).
//   DONE      : pulse wr_done with wr_error, clear retry, set pointer=owner+1 mod NUM_REQ, go to GAP(then IDLE).
//   GAP       : count GAP_CYCLES with i2c_go=0, then go to the recorded next state.
//  Abort (timeout): i2c_go=0, wr_done=1, wr_error=1, then GAP; the timeout counter restarts on every state entry.
//  Minimum latency from accept to wr_done is 6 cycles plus engine time, with no retry.
//  Only one write is outstanding at a time. Requests arriving during busy wait; they are not lost while valid is held.
//  Simultaneous valid requests: the lowest index at or after the pointer wins. The pointer advances only in DONE.
//  enable falling mid-transaction: the current write completes; no new grant is made until enable=1.
//  reset_n asserted mid-transaction: immediate return to reset values; the captured write is dropped, not replayed.
//  i2c_data and wr_owner are stable from START until the next accept.
// TESTING
//  1 Single write: req0 addr=0x09 data=0x0400, ACK -> i2c_data=0xBA090400, one go, wr_done=1, wr_error=0.
//  2 Contention: req0 and req1 valid together, pointer=0 -> owner 0 then owner 1, one accept each, in order.
//  3 NACK twice then ACK, MAX_RETRY=3 -> 3 go pulses, a single wr_done, wr_error=0.
//  4 NACK always, MAX_RETRY=3 -> 4 transactions, then wr_done=1 and wr_error=1; pointer advances.
//  5 i2c_end stuck 1 after go, TIMEOUT_CYCLES=100 -> abort at about 100 cycles, wr_error=1, i2c_go=0.
//  6 enable=0 with req_valid=1 -> no accept; raise enable -> accept within 1 cycle. reset_n mid-WAIT_LOW -> all outputs 0.

Source files
------------

// File: rtl/camera_reg_write_arbiter.sv
// camera_reg_write_arbiter
// Schedules run-time sensor register writes onto the shared I2C transaction engine.
// Requesters are served round-robin. Each 8-bit-address/16-bit-data write becomes one
// engine transaction. A NACK causes a retry after an idle gap. A wait that never ends
// is aborted after a timeout. i2c_end/i2c_ack are resynchronised before any use.
module camera_reg_write_arbiter #(
  parameter int         NUM_REQ        = 2,
  parameter logic [7:0] SLAVE_ADDR     = 8'hBA,
  parameter int         MAX_RETRY      = 3,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         GAP_CYCLES     = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [8*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_accept,
  output logic                    wr_done,
  output logic                    wr_error,
  output logic [1:0]              wr_owner,
  output logic                    busy,
  output logic                    i2c_go,
  output logic [31:0]             i2c_data,
  input  logic                    i2c_end,
  input  logic                    i2c_ack
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_LOW, S_WAIT_HIGH, S_CHECK, S_DONE, S_GAP
  } state_t;

  state_t             state_q, state_d;
  state_t             gap_next_q, gap_next_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] accept_q, accept_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         owner_q, owner_d;
  logic               busy_q, busy_d;
  logic               go_q, go_d;
  logic [31:0]        data_q, data_d;
  logic               end_s1_q, end_s1_d, end_s2_q, end_s2_d;
  logic               ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d;
  logic [2:0]         pick;
  logic               tmo_expired;

  // Round-robin choice: {found, index} of the first valid requester at or after p.
  function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [1:0] p);
    logic [2:0]         r;
    logic [NUM_REQ-1:0] sh;
    int                 idx;
    r = 3'b000;
    // Walk from the farthest candidate back to p so the nearest valid one is kept last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      sh  = v >> idx;
      if (sh[0]) r = {1'b1, 2'(idx)};
    end
    return r;
  endfunction

  assign pick        = rr_pick(req_valid, ptr_q);
  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Next-state, counter and registered-output computation for the write scheduler.
  always_comb begin
    state_d    = state_q;
    gap_next_d = gap_next_q;
    ptr_d      = ptr_q;
    retry_d    = retry_q;
    gap_d      = gap_q;
    ack_d      = ack_q;
    err_d      = err_q;
    accept_d   = '0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    owner_d    = owner_q;
    go_d       = go_q;
    data_d     = data_q;
    end_s1_d   = i2c_end;
    end_s2_d   = end_s1_q;
    ack_s1_d   = i2c_ack;
    ack_s2_d   = ack_s1_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && pick[2]) begin
          accept_d = NUM_REQ'(1) << pick[1:0];
          owner_d  = pick[1:0];
          data_d   = {SLAVE_ADDR, req_addr[pick[1:0]*8 +: 8], req_data[pick[1:0]*16 +: 16]};
          err_d    = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        go_d    = 1'b1;
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!end_s2_q) begin
          state_d = S_WAIT_HIGH;
        end else if (tmo_expired) begin
          go_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT_HIGH: begin
        if (end_s2_q) begin
          go_d    = 1'b0;
          ack_d   = ack_s2_q;
          state_d = S_CHECK;
        end else if (tmo_expired) begin
          go_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_CHECK: begin
        if (!ack_q) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d    = retry_q + RTY_W'(1);
          gap_next_d = S_START;
          state_d    = S_GAP;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d     = 1'b1;
        error_d    = err_q;
        retry_d    = '0;
        ptr_d      = (int'(owner_q) == NUM_REQ - 1) ? 2'd0 : owner_q + 2'd1;
        gap_next_d = S_IDLE;
        state_d    = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = gap_next_q;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The timeout only runs while waiting on the engine and restarts on every state entry.
    if ((state_q == S_WAIT_LOW || state_q == S_WAIT_HIGH) && state_d == state_q) begin
      tmo_d = tmo_q + TMO_W'(1);
    end else begin
      tmo_d = '0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State, counters, synchronisers and registered outputs; reset drops any captured write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      gap_next_q <= S_IDLE;
      ptr_q      <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      accept_q   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      go_q       <= 1'b0;
      data_q     <= '0;
      end_s1_q   <= 1'b1;   // engine idle level
      end_s2_q   <= 1'b1;
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_next_q <= gap_next_d;
      ptr_q      <= ptr_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      accept_q   <= accept_d;
      done_q     <= done_d;
      error_q    <= error_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      go_q       <= go_d;
      data_q     <= data_d;
      end_s1_q   <= end_s1_d;
      end_s2_q   <= end_s2_d;
      ack_s1_q   <= ack_s1_d;
      ack_s2_q   <= ack_s2_d;
    end
  end

  assign req_accept = accept_q;
  assign wr_done    = done_q;
  assign wr_error   = error_q;
  assign wr_owner   = owner_q;
  assign busy       = busy_q;
  assign i2c_go     = go_q;
  assign i2c_data   = data_q;

endmodule

// File: tb/tb_camera_reg_write_arbiter.sv
// Testbench for camera_reg_write_arbiter: a simple I2C engine model answers go requests
// with a programmable number of NACKs; a transaction-level model predicts owners,
// attempt counts and error flags.
module tb_camera_reg_write_arbiter;

  localparam int         NUM_REQ        = 2;
  localparam int         MAX_RETRY      = 3;
  localparam int         TIMEOUT_CYCLES = 100;
  localparam int         GAP_CYCLES     = 64;
  localparam logic [7:0] SLAVE          = 8'hBA;

  logic                  clock;
  logic                  reset_n;
  logic                  enable;
  logic [NUM_REQ-1:0]    req_valid;
  logic [8*NUM_REQ-1:0]  req_addr;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_accept;
  logic                  wr_done, wr_error, busy, i2c_go, i2c_end, i2c_ack;
  logic [1:0]            wr_owner;
  logic [31:0]           i2c_data;

  int checks = 0;
  int errors = 0;
  int nack_left = 0;
  bit stuck = 1'b0;
  int ptr_m = 0;

  camera_reg_write_arbiter #(
    .NUM_REQ(NUM_REQ), .SLAVE_ADDR(SLAVE), .MAX_RETRY(MAX_RETRY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_accept(req_accept), .wr_done(wr_done), .wr_error(wr_error),
    .wr_owner(wr_owner), .busy(busy), .i2c_go(i2c_go), .i2c_data(i2c_data),
    .i2c_end(i2c_end), .i2c_ack(i2c_ack)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // I2C engine model: on go, drop end, run a while, report ACK/NACK, raise end, wait for go low.
  initial begin
    i2c_end = 1'b1;
    i2c_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && i2c_go && !stuck) begin
        repeat (3) @(negedge clock);
        i2c_end = 1'b0;
        repeat (4 + $urandom_range(0, 4)) @(negedge clock);
        i2c_ack = (nack_left > 0);
        if (nack_left > 0) nack_left--;
        i2c_end = 1'b1;
        while (i2c_go) @(negedge clock);
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic bit bit_at(input logic [NUM_REQ-1:0] m, input int i);
    logic [NUM_REQ-1:0] s;
    s = m >> i;
    return s[0];
  endfunction

  // Round-robin rule: first pending index at or after the pointer, wrapping.
  function automatic int rr_model(input logic [NUM_REQ-1:0] pend, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (bit_at(pend, (ptr + k) % NUM_REQ)) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [15:0] d);
    req_addr[i*8 +: 8]   = a;
    req_data[i*16 +: 16] = d;
    req_valid[i]         = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; enable = 1'b0; req_valid = '0; nack_left = 0; stuck = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ptr_m = 0;
    @(negedge clock);
  endtask

  // Runs until the next wr_done (or budget), behaving as the requesters: valid drops on accept.
  task automatic run_write(input int budget, output bit seen, output bit err,
                           output logic [1:0] owner, output logic [31:0] data,
                           output int goes, output int accs, output int acc_idx,
                           output logic go_at_done, output int go_cyc, output int done_cyc);
    logic go_prev;
    seen = 1'b0; err = 1'b0; owner = '0; data = '0; goes = 0; accs = 0; acc_idx = -1;
    go_at_done = 1'b0; go_cyc = -1; done_cyc = -1;
    go_prev = i2c_go;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (req_accept != '0) begin
        accs++;
        for (int i = 0; i < NUM_REQ; i++)
          if (bit_at(req_accept, i)) begin
            if (acc_idx < 0) acc_idx = i;
            req_valid[i] = 1'b0;
          end
      end
      if (i2c_go && !go_prev) begin
        goes++;
        if (go_cyc < 0) go_cyc = c;
      end
      go_prev = i2c_go;
      if (wr_done) begin
        seen = 1'b1; err = wr_error; owner = wr_owner; data = i2c_data;
        go_at_done = i2c_go; done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if ({req_accept, wr_done, wr_error, wr_owner, busy, i2c_go} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {req_accept, wr_done, wr_error, wr_owner, busy, i2c_go});
    end
    checks++;
    if (i2c_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", i2c_data); end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    ptr_m = 0;
  endtask

  task automatic test_single_write();
    bit seen, err; logic [1:0] own; logic [31:0] dat; int goes, accs, aidx, gc, dc; logic gad;
    enable = 1'b1; nack_left = 0;
    set_req(0, 8'h09, 16'h0400);
    run_write(2000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", seen); end
    checks++;
    if (dat !== 32'hBA090400) begin errors++; $display("FAIL single_data got %h want BA090400", dat); end
    checks++;
    if (goes != 1) begin errors++; $display("FAIL single_goes got %0d want 1", goes); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err); end
    checks++;
    if (own !== 2'd0 || accs != 1 || aidx != 0) begin
      errors++; $display("FAIL single_owner got owner %0d accepts %0d idx %0d want 0 1 0", own, accs, aidx);
    end
    ptr_m = 1;
  endtask

  task automatic test_contention();
    bit seen, err; logic [1:0] own; logic [31:0] dat; int goes, accs, aidx, gc, dc; logic gad;
    logic [NUM_REQ-1:0] pend; logic [7:0] am[NUM_REQ]; logic [15:0] dm[NUM_REQ]; int oe;
    do_reset();
    enable = 1'b1; nack_left = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      am[i] = 8'($urandom); dm[i] = 16'($urandom);
      set_req(i, am[i], dm[i]);
    end
    pend = '1;
    for (int w = 0; w < NUM_REQ; w++) begin
      oe = rr_model(pend, ptr_m);
      run_write(2000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
      checks++;
      if (!seen || int'(own) != oe || aidx != oe || accs != 1) begin
        errors++;
        $display("FAIL contention_owner w%0d got owner %0d idx %0d accepts %0d want %0d", w, own, aidx, accs, oe);
      end
      checks++;
      if (dat !== {SLAVE, am[oe], dm[oe]}) begin
        errors++; $display("FAIL contention_data w%0d got %h want %h", w, dat, {SLAVE, am[oe], dm[oe]});
      end
      pend = pend & ~(NUM_REQ'(1) << oe);
      ptr_m = (oe + 1) % NUM_REQ;
    end
  endtask

  task automatic test_nack_retry();
    bit seen, err; logic [1:0] own; logic [31:0] dat; int goes, accs, aidx, gc, dc; logic gad;
    logic [15:0] d;
    d = 16'($urandom);
    nack_left = 2;
    set_req(0, 8'h3C, d);
    run_write(3000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
    checks++;
    if (!seen || goes != 3 || err !== 1'b0) begin
      errors++; $display("FAIL nack_retry got done %b goes %0d err %b want 1 3 0", seen, goes, err);
    end
    checks++;
    if (dat !== {SLAVE, 8'h3C, d}) begin errors++; $display("FAIL nack_retry_data got %h want %h", dat, {SLAVE, 8'h3C, d}); end
    ptr_m = 1;
  endtask

  task automatic test_nack_exhaust();
    bit seen, err; logic [1:0] own; logic [31:0] dat; int goes, accs, aidx, gc, dc; logic gad; int oe;
    nack_left = 10;
    set_req(1, 8'h55, 16'hA5A5);
    run_write(3000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
    checks++;
    if (!seen || goes != MAX_RETRY + 1 || err !== 1'b1 || own !== 2'd1) begin
      errors++; $display("FAIL nack_exhaust got done %b goes %0d err %b owner %0d want 1 %0d 1 1", seen, goes, err, own, MAX_RETRY + 1);
    end
    ptr_m = 0;
    nack_left = 0;
    set_req(0, 8'h01, 16'h0001);
    set_req(1, 8'h02, 16'h0002);
    oe = rr_model('1, ptr_m);
    run_write(2000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
    checks++;
    if (!seen || int'(own) != oe || err !== 1'b0) begin
      errors++; $display("FAIL ptr_after_error got owner %0d err %b want %0d 0", own, err, oe);
    end
    run_write(2000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
    checks++;
    if (!seen || int'(own) != 1 - oe) begin
      errors++; $display("FAIL ptr_after_error_second got owner %0d want %0d", own, 1 - oe);
    end
  endtask

  task automatic test_timeout();
    bit seen, err; logic [1:0] own; logic [31:0] dat; int goes, accs, aidx, gc, dc; logic gad;
    stuck = 1'b1;
    set_req(0, 8'h77, 16'h1234);
    run_write(2000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
    checks++;
    if (!seen || err !== 1'b1 || gad !== 1'b0) begin
      errors++; $display("FAIL timeout_abort got done %b err %b go %b want 1 1 0", seen, err, gad);
    end
    checks++;
    if (gc < 0 || (dc - gc) < TIMEOUT_CYCLES - 5 || (dc - gc) > TIMEOUT_CYCLES + 10) begin
      errors++; $display("FAIL timeout_latency got %0d cycles want about %0d", dc - gc, TIMEOUT_CYCLES);
    end
    stuck = 1'b0;
  endtask

  task automatic test_enable_gate();
    bit seen, err; logic [1:0] own; logic [31:0] dat; int goes, accs, aidx, gc, dc; logic gad;
    int seen_acc;
    enable = 1'b0;
    repeat (GAP_CYCLES + 16) @(negedge clock);
    set_req(1, 8'h42, 16'hBEEF);
    seen_acc = 0;
    repeat (20) begin
      @(negedge clock);
      if (req_accept != '0) seen_acc++;
    end
    checks++;
    if (seen_acc != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL enable_hold got accepts %0d busy %b want 0 0", seen_acc, busy);
    end
    enable = 1'b1;
    @(negedge clock);
    checks++;
    if (req_accept !== 2'b10) begin errors++; $display("FAIL enable_accept got %b want 10", req_accept); end
    req_valid = '0;
    run_write(2000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
    checks++;
    if (!seen || own !== 2'd1 || dat !== 32'hBA42BEEF) begin
      errors++; $display("FAIL enable_write got done %b owner %0d data %h want 1 1 BA42BEEF", seen, own, dat);
    end
  endtask

  task automatic test_reset_mid();
    int waited, extra;
    repeat (GAP_CYCLES + 4) @(negedge clock);
    enable = 1'b1;
    set_req(0, 8'h10, 16'h2020);
    waited = 0;
    while (!i2c_go && waited < 50) begin
      @(negedge clock);
      if (req_accept != '0) req_valid = '0;
      waited++;
    end
    checks++;
    if (i2c_go !== 1'b1) begin errors++; $display("FAIL reset_mid_go got %b want 1", i2c_go); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({req_accept, wr_done, wr_error, wr_owner, busy, i2c_go, i2c_data} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got %h want 0", {req_accept, wr_done, wr_error, wr_owner, busy, i2c_go, i2c_data});
    end
    @(negedge clock);
    req_valid = '0;
    reset_n = 1'b1;
    ptr_m = 0;
    extra = 0;
    repeat (100) begin
      @(negedge clock);
      if (wr_done || req_accept != '0 || busy) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL reset_mid_replay got %0d active cycles want 0", extra); end
  endtask

  task automatic test_random();
    bit seen, err; logic [1:0] own; logic [31:0] dat; int goes, accs, aidx, gc, dc; logic gad;
    logic [NUM_REQ-1:0] pend; logic [7:0] am[NUM_REQ]; logic [15:0] dm[NUM_REQ];
    int left, used, oe, goes_e; bit err_e;
    enable = 1'b1;
    for (int it = 0; it < 6; it++) begin
      pend = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      left = $urandom_range(0, 5);
      nack_left = left;
      for (int i = 0; i < NUM_REQ; i++) begin
        am[i] = 8'($urandom); dm[i] = 16'($urandom);
        if (bit_at(pend, i)) set_req(i, am[i], dm[i]);
      end
      for (int w = 0; w < NUM_REQ && pend != '0; w++) begin
        oe     = rr_model(pend, ptr_m);
        used   = (left > MAX_RETRY) ? MAX_RETRY + 1 : left;
        err_e  = (left > MAX_RETRY);
        goes_e = err_e ? used : used + 1;
        left   = left - used;
        run_write(4000, seen, err, own, dat, goes, accs, aidx, gad, gc, dc);
        checks++;
        if (!seen || int'(own) != oe || dat !== {SLAVE, am[oe], dm[oe]}) begin
          errors++;
          $display("FAIL random_write it%0d w%0d got done %b owner %0d data %h want owner %0d data %h",
                   it, w, seen, own, dat, oe, {SLAVE, am[oe], dm[oe]});
        end
        checks++;
        if (goes != goes_e || err !== err_e) begin
          errors++; $display("FAIL random_retry it%0d w%0d got goes %0d err %b want %0d %b", it, w, goes, err, goes_e, err_e);
        end
        pend  = pend & ~(NUM_REQ'(1) << oe);
        ptr_m = (oe + 1) % NUM_REQ;
      end
      checks++;
      if (nack_left != left) begin errors++; $display("FAIL random_nacks it%0d got %0d left want %0d", it, nack_left, left); end
      nack_left = 0;
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    test_reset();
    test_single_write();
    test_contention();
    test_nack_retry();
    test_nack_exhaust();
    test_timeout();
    test_enable_gate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
